// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types: register index width, scoreboard entry, control bundle
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

endpackage

// File: rtl/hazard_scheduler_if.sv
// rtl/hazard_scheduler_if.sv - decoder/pipeline side signals of the hazard scheduler
interface hazard_scheduler_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  id_reg_write;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  id_mem_read;
  logic                  id_jump;
  logic                  ex_branch_taken;
  logic                  mem_busy;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
           id_dest, id_mem_read, id_jump, ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_flush, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_reg_write,
           id_dest, id_mem_read, id_jump, ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_flush, stall_count
  );

endinterface

// File: rtl/hazard_scheduler_match.sv
// rtl/hazard_scheduler_match.sv - compares one scoreboard entry against the ID source registers
module hazard_match
  import mips_pkg::*;
#(
  parameter int   REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter logic LOAD_ONLY  = 1'b0
) (
  input  sb_entry_t             entry,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  output logic                  hit
);

  logic src_hit;

  assign src_hit = (id_uses_rs & (id_rs == entry.dest)) |
                   (id_uses_rt & (id_rt == entry.dest));

  // LOAD_ONLY restricts the hazard to load producers when a forwarding unit covers the rest
  assign hit = id_valid & entry.valid & (entry.dest != REG_ZERO) & src_hit &
               (entry.is_load | ~LOAD_ONLY);

endmodule

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - ID-stage stall/flush sequencer with EX/MEM write scoreboard
// Build option: HAZARD_SCHEDULER_FORWARDING_EN (load-use interlock only).
module hazard_scheduler
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scheduler_if.slave bus
);

  // Entries leaving MEM are in WB, which the write-first register file resolves, so no WB copy is kept.
  sb_entry_t        sb_ex;
  sb_entry_t        sb_mem;
  logic             ex_hit;
  logic             mem_hit;
  logic             raw_stall;
  logic             stall_now;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] stall_cnt;

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
  localparam logic EX_LOAD_ONLY = 1'b1;
`else
  localparam logic EX_LOAD_ONLY = 1'b0;
`endif

  hazard_match #(.REG_ADDR_W(REG_ADDR_W), .LOAD_ONLY(EX_LOAD_ONLY)) u_match_ex (
    .entry      (sb_ex),
    .id_valid   (bus.id_valid),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rs (bus.id_uses_rs),
    .id_uses_rt (bus.id_uses_rt),
    .hit        (ex_hit)
  );

  hazard_match #(.REG_ADDR_W(REG_ADDR_W), .LOAD_ONLY(1'b0)) u_match_mem (
    .entry      (sb_mem),
    .id_valid   (bus.id_valid),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rs (bus.id_uses_rs),
    .id_uses_rt (bus.id_uses_rt),
    .hit        (mem_hit)
  );

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
  assign raw_stall = ex_hit;
`else
  assign raw_stall = ex_hit | mem_hit;
`endif

  always_comb begin
    ctrl      = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    stall_now = 1'b0;
    if (reset) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    end else if (bus.mem_busy) begin
      ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};
    end else if (bus.ex_branch_taken) begin
      ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
    end else if (bus.id_jump) begin
      ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};
    end else if (raw_stall) begin
      ctrl      = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
      stall_now = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_ex     <= '0;
      sb_mem    <= '0;
      stall_cnt <= '0;
    end else if (!bus.mem_busy) begin
      sb_mem        <= sb_ex;
      sb_ex.valid   <= bus.id_valid & bus.id_reg_write & ~ctrl.idex_flush;
      sb_ex.dest    <= bus.id_dest;
      sb_ex.is_load <= bus.id_mem_read;
      if (stall_now && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ifid_write  = ctrl.ifid_write;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed test-plan steps plus random cycles against a producer-list model
module tb_hazard_scheduler;

  logic clk = 1'b0;
  logic reset;

  hazard_scheduler_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();

  hazard_scheduler #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dest;
    bit is_load;
    int age;
  } prod_t;

  prod_t prods[$];
  int    m_count;
  int    n_cmp;
  int    n_fail;
  bit    e_pc, e_wr, e_iff, e_idf, e_wr_chk, e_stall;

`ifdef HAZARD_SCHEDULER_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic bit model_hazard();
    bit h = 1'b0;
    if (!bus.id_valid) return 1'b0;
    foreach (prods[i]) begin
      bit in_window = FWD ? (prods[i].age == 0 && prods[i].is_load) : (prods[i].age <= 1);
      bit reads = (bus.id_uses_rs && int'(bus.id_rs) == prods[i].dest) ||
                  (bus.id_uses_rt && int'(bus.id_rt) == prods[i].dest);
      if (in_window && prods[i].dest != 0 && reads) h = 1'b1;
    end
    return h;
  endfunction

  task automatic compute_expected();
    e_stall  = 1'b0;
    e_wr_chk = 1'b1;
    if (reset) begin
      {e_pc, e_wr, e_iff, e_idf} = 4'b0011;
    end else if (bus.mem_busy) begin
      {e_pc, e_wr, e_iff, e_idf} = 4'b0000;
    end else if (bus.ex_branch_taken) begin
      {e_pc, e_wr, e_iff, e_idf} = 4'b1011;
      e_wr_chk = 1'b0;
    end else if (bus.id_jump) begin
      {e_pc, e_wr, e_iff, e_idf} = 4'b1010;
      e_wr_chk = 1'b0;
    end else if (model_hazard()) begin
      {e_pc, e_wr, e_iff, e_idf} = 4'b0001;
      e_stall = 1'b1;
    end else begin
      {e_pc, e_wr, e_iff, e_idf} = 4'b1100;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      prods.delete();
      m_count = 0;
    end else if (!bus.mem_busy) begin
      prod_t nq[$];
      foreach (prods[i]) begin
        if (prods[i].age < 1) begin
          prod_t p = prods[i];
          p.age++;
          nq.push_back(p);
        end
      end
      prods = nq;
      if (bus.id_valid && bus.id_reg_write && !e_idf) begin
        prod_t p;
        p.dest    = int'(bus.id_dest);
        p.is_load = bus.id_mem_read;
        p.age     = 0;
        prods.push_back(p);
      end
      if (e_stall && m_count < 65535) m_count++;
    end
  endtask

  task automatic step();
    compute_expected();
    @(negedge clk);
    chk("pc_write", int'(bus.pc_write), int'(e_pc));
    chk("ifid_flush", int'(bus.ifid_flush), int'(e_iff));
    chk("idex_flush", int'(bus.idex_flush), int'(e_idf));
    chk("stall_count", int'(bus.stall_count), m_count);
    if (e_wr_chk) chk("ifid_write", int'(bus.ifid_write), int'(e_wr));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_instr(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                           input bit rw, input int dest, input bit mr, input bit jmp);
    bus.id_valid     = v;
    bus.id_rs        = 5'(rs);
    bus.id_rt        = 5'(rt);
    bus.id_uses_rs   = urs;
    bus.id_uses_rt   = urt;
    bus.id_reg_write = rw;
    bus.id_dest      = 5'(dest);
    bus.id_mem_read  = mr;
    bus.id_jump      = jmp;
  endtask

  task automatic bubble();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bubble();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    m_count = 0;
    reset   = 1'b1;
    bus.ex_branch_taken = 1'b0;
    bus.mem_busy        = 1'b0;
    bubble();
    #1;

    // reset state
    step();
    chk("reset_pc_write", int'(bus.pc_write), 0);
    reset = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    set_instr(1, 1, 2, 1, 1, 1, 3, 0, 0); step();
    set_instr(1, 3, 5, 1, 1, 1, 4, 0, 0); step(); step(); step();
    bubble(); step();
    chk("raw_alu_count", int'(bus.stall_count), FWD ? 0 : 2);

    // lw $8,0($9) ; add $10,$8,$8
    do_reset();
    set_instr(1, 9, 0, 1, 0, 1, 8, 1, 0); step();
    set_instr(1, 8, 8, 1, 1, 1, 10, 0, 0); step(); step(); step();
    bubble(); step();
    chk("load_use_count", int'(bus.stall_count), FWD ? 1 : 2);

    // $0 producer then $0 consumer
    do_reset();
    set_instr(1, 1, 2, 1, 1, 1, 0, 0, 0); step();
    set_instr(1, 0, 0, 1, 1, 1, 5, 0, 0); step();
    chk("zero_reg_pc_write", int'(bus.pc_write), 1);
    bubble(); step();
    chk("zero_reg_count", int'(bus.stall_count), 0);

    // branch + jump + raw stall together, then a consumer of the discarded instruction
    do_reset();
    set_instr(1, 1, 2, 1, 1, 1, 3, 0, 0); step();
    set_instr(1, 3, 5, 1, 1, 1, 4, 0, 1);
    bus.ex_branch_taken = 1'b1;
    step();
    bus.ex_branch_taken = 1'b0;
    set_instr(1, 4, 0, 1, 0, 1, 6, 0, 0); step();
    chk("branch_ex_bubble_pc", int'(bus.pc_write), 1);
    bubble(); step();
    chk("branch_count", int'(bus.stall_count), 0);

    // mem_busy during a pending stall
    do_reset();
    set_instr(1, 1, 2, 1, 1, 1, 3, 0, 0); step();
    set_instr(1, 3, 5, 1, 1, 1, 4, 0, 0); step();
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.mem_busy = 1'b0;
    step(); step();
    bubble(); step();
    chk("busy_stall_count", int'(bus.stall_count), FWD ? 0 : 2);

    // reset mid-stall
    do_reset();
    set_instr(1, 1, 2, 1, 1, 1, 3, 0, 0); step();
    set_instr(1, 3, 5, 1, 1, 1, 4, 0, 0); step();
    reset = 1'b1; step(); reset = 1'b0;
    step();
    chk("post_reset_pc_write", int'(bus.pc_write), 1);
    chk("post_reset_idex_flush", int'(bus.idex_flush), 0);
    chk("post_reset_count", int'(bus.stall_count), 0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset               = ($urandom_range(49) == 0);
      bus.mem_busy        = ($urandom_range(7) == 0);
      bus.ex_branch_taken = ($urandom_range(11) == 0);
      set_instr($urandom_range(7) != 0, $urandom_range(3), $urandom_range(3),
                $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom_range(3) != 0,
                $urandom_range(3), $urandom_range(2) == 0, $urandom_range(11) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
